dmem_lsu: RTL and testbench

Load/store unit sitting between the core's execute stage and the byte-enabled, 1-cycle-latency data memory. Accepts byte/half/word load and store requests on a byte address, drives word address, shifted write data and per-byte write enables to the memory, and returns sign- or zero-extended load data. Misaligned accesses that straddle a word boundary are split into two consecutive memory accesses and merged.

---
 rtl/dmem_lsu.sv | 182 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit between execute and a byte-enabled, 1-cycle-latency data memory.
// Word-straddling accesses are split into two back-to-back memory accesses and merged.
module dmem_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] rotl_lanes(input logic [31:0] w, input logic [1:0] off);
        logic [31:0] r;
        case (off)
            2'd0:    r = w;
            2'd1:    r = {w[23:0], w[31:24]};
            2'd2:    r = {w[15:0], w[31:16]};
            default: r = {w[7:0],  w[31:8]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] f;
        case (size)
            2'b00:   f = uns ? {24'h000000, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   f = uns ? {16'h0000, d[15:0]}   : {{16{d[15]}}, d[15:0]};
            default: f = d;
        endcase
        return f;
    endfunction

    state_t      state_r;
    logic [1:0]  off_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic        write_r;
    logic        split_r;
    logic [15:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  mask_hi_r;
    logic [31:0] low_r;

    logic [1:0]  off_s;
    logic [7:0]  mask8_s;
    logic        split_s;
    logic [31:0] wrot_s;
    logic        second_s;
    logic        accept_s;
    logic [3:0]  we_s;
    logic [63:0] merged_s;
    logic [31:0] field_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^req_addr[31:18];

    assign off_s    = req_addr[1:0];
    assign mask8_s  = {4'h0, size_mask(req_size)} << off_s;
    assign split_s  = ({1'b0, off_s} + size_bytes(req_size)) > 3'd4;
    assign wrot_s   = rotl_lanes(req_wdata, off_s);

    assign second_s  = (state_r == WAIT1) && split_r;
    assign req_ready = (state_r == IDLE) || ((state_r == WAIT1) && !split_r) || (state_r == WAIT2);
    assign accept_s  = req_valid && req_ready && !reset;

    // Memory port: second half of a split takes priority, otherwise the accepted request.
    always_comb begin
        mem_addr       = 16'h0000;
        mem_write_data = 32'h0000_0000;
        we_s           = 4'b0000;
        if (second_s) begin
            mem_addr       = addr_r + 16'd1;
            mem_write_data = wdata_r;
            we_s           = write_r ? mask_hi_r : 4'b0000;
        end else if (accept_s) begin
            mem_addr       = req_addr[17:2];
            mem_write_data = wrot_s;
            we_s           = req_write ? mask8_s[3:0] : 4'b0000;
        end else begin
            mem_addr       = 16'h0000;
            mem_write_data = 32'h0000_0000;
            we_s           = 4'b0000;
        end
    end

    assign mem_write_enable = reset ? 4'b0000 : we_s;

    // Response path: merge both words of a split, then align and extend the field.
    always_comb begin
        resp_valid = (state_r == WAIT2) || ((state_r == WAIT1) && !split_r);
        merged_s   = (state_r == WAIT2) ? {mem_read_data, low_r} : {32'h0000_0000, mem_read_data};
        field_s    = 32'(merged_s >> {off_r, 3'b000});
        if (resp_valid && !write_r) begin
            resp_rdata = extend(field_s, size_r, unsigned_r);
        end else begin
            resp_rdata = 32'h0000_0000;
        end
    end

    // Access sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= accept_s ? WAIT1 : IDLE;
                WAIT1:   state_r <= split_r ? WAIT2 : (accept_s ? WAIT1 : IDLE);
                WAIT2:   state_r <= accept_s ? WAIT1 : IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Request attributes captured on accept for the follow-up cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_r      <= 2'b00;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            write_r    <= 1'b0;
            split_r    <= 1'b0;
            addr_r     <= 16'h0000;
            wdata_r    <= 32'h0000_0000;
            mask_hi_r  <= 4'b0000;
        end else if (accept_s) begin
            off_r      <= off_s;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            write_r    <= req_write;
            split_r    <= split_s;
            addr_r     <= req_addr[17:2];
            wdata_r    <= wrot_s;
            mask_hi_r  <= mask8_s[7:4];
        end
    end

    // Low word of a split load, returned while the second access is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_r <= 32'h0000_0000;
        end else if (second_s) begin
            low_r <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a write-first byte-enabled memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_read_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [65536];

    dmem_lsu dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Write-first memory, one cycle read latency.
    always @(posedge clk) begin : mem_model
        logic [31:0] w;
        w = mem[mem_addr];
        for (int i = 0; i < 4; i++) begin
            if (mem_write_enable[i]) w[8*i +: 8] = mem_write_data[8*i +: 8];
        end
        mem[mem_addr] <= w;
        mem_read_data <= w;
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(posedge clk); #1;
        drive(v.wr, v.size, v.uns, v.addr, v.wdata);
        @(negedge clk);
        chk({name, ".ready"}, 32'(req_ready), 32'd1);
        chk({name, ".addr"}, 32'(mem_addr), 32'(v.e_addr));
        chk({name, ".we"}, 32'(mem_write_enable), 32'(v.e_we));
        chk({name, ".acc_rv"}, 32'(resp_valid), 32'd0);
        if (v.wr) chk({name, ".wdata"}, mem_write_data, v.e_wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, ".rv"}, 32'(resp_valid), 32'd1);
        chk({name, ".rdata"}, resp_rdata, v.e_rdata);
    endtask

    task automatic run_split(input string name, input logic wr, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [15:0] a1, input logic [3:0] we1,
                             input logic [15:0] a2, input logic [3:0] we2,
                             input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        @(posedge clk); #1;
        drive(wr, size, uns, addr, wdata);
        @(negedge clk);
        chk({name, ".addr1"}, 32'(mem_addr), 32'(a1));
        chk({name, ".we1"}, 32'(mem_write_enable), 32'(we1));
        if (wr) chk({name, ".wdata1"}, mem_write_data, e_wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, ".ready_w1"}, 32'(req_ready), 32'd0);
        chk({name, ".rv_w1"}, 32'(resp_valid), 32'd0);
        chk({name, ".addr2"}, 32'(mem_addr), 32'(a2));
        chk({name, ".we2"}, 32'(mem_write_enable), 32'(we2));
        if (wr) chk({name, ".wdata2"}, mem_write_data, e_wdata);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, ".rv"}, 32'(resp_valid), 32'd1);
        chk({name, ".rdata"}, resp_rdata, e_rdata);
        chk({name, ".we_w2"}, 32'(mem_write_enable), 32'd0);
    endtask

    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0000_0000;
        mem_read_data = 32'h0000_0000;

        //            wr    size   uns   addr          wdata          e_addr    e_we     e_wdata        e_rdata
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 16'h0040, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0080, 16'h0040, 4'b1000, 32'h8000_0000, 32'h0000_0000};
        vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'hFFFF_FF80};
        vt[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'h0000_0080};
        vt[5]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_00EF, 16'h0040, 4'b0100, 32'h00EF_0000, 32'h0000_0000};
        vt[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'h0000_80EF};
        vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'hFFFF_80EF};
        vt[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0106, 32'h0000_1234, 16'h0041, 4'b1100, 32'h1234_0000, 32'h0000_0000};
        vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0000_0000, 16'h0041, 4'b0000, 32'h0000_0000, 32'h1234_0000};
        vt[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'h80EF_BEEF};
        vt[11] = '{1'b0, 2'b00, 1'b1, 32'hFFFC_0101, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'h0000_00BE};
        vt[12] = '{1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'hFFFF_FF5A, 16'h0040, 4'b0010, 32'hFFFF_5AFF, 32'h0000_0000};
        vt[13] = '{1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'h0000_5AEF};
        vt[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000, 16'h0040, 4'b0000, 32'h0000_0000, 32'h80EF_5AEF};

        b2b_addr[0] = 32'h0000_0100; b2b_exp[0] = 32'h80EF_5AEF;
        b2b_addr[1] = 32'h0000_0104; b2b_exp[1] = 32'h1234_0000;
        b2b_addr[2] = 32'h0000_0200; b2b_exp[2] = 32'h2233_4400;
        b2b_addr[3] = 32'h0000_0204; b2b_exp[3] = 32'h0000_0011;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0000;
        req_wdata    = 32'h0000_0000;
        #1;
        chk("rst.rv", 32'(resp_valid), 32'd0);
        chk("rst.we", 32'(mem_write_enable), 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        run_split("split_st", 1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'h1122_3344,
                  16'h0080, 4'b1110, 16'h0081, 4'b0001, 32'h2233_4411, 32'h0000_0000);
        run_split("split_ld", 1'b0, 2'b10, 1'b0, 32'h0000_0201, 32'h0000_0000,
                  16'h0080, 4'b0000, 16'h0081, 4'b0000, 32'h0000_0000, 32'h1122_3344);
        run_split("wrap_st", 1'b1, 2'b01, 1'b0, 32'h0003_FFFF, 32'h0000_ABCD,
                  16'hFFFF, 4'b1000, 16'h0000, 4'b0001, 32'hCD00_00AB, 32'h0000_0000);
        run_split("wrap_ld", 1'b0, 2'b01, 1'b0, 32'h0003_FFFF, 32'h0000_0000,
                  16'hFFFF, 4'b0000, 16'h0000, 4'b0000, 32'h0000_0000, 32'hFFFF_ABCD);

        // Four aligned loads issued on consecutive cycles.
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 1'b0, b2b_addr[0], 32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk($sformatf("b2b%0d.ready", i), 32'(req_ready), 32'd1);
                chk($sformatf("b2b%0d.addr", i), 32'(mem_addr), {18'h0, b2b_addr[i][15:2]});
            end
            if (i > 0) begin
                chk($sformatf("b2b%0d.rv", i - 1), 32'(resp_valid), 32'd1);
                chk($sformatf("b2b%0d.rdata", i - 1), resp_rdata, b2b_exp[i - 1]);
            end else begin
                chk("b2b.first_rv", 32'(resp_valid), 32'd0);
            end
            @(posedge clk); #1;
            if (i < 3) drive(1'b0, 2'b10, 1'b0, b2b_addr[i + 1], 32'h0000_0000);
            else req_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b.idle_rv", 32'(resp_valid), 32'd0);

        // Reset while the second half of a split store is being issued.
        @(posedge clk); #1;
        drive(1'b1, 2'b10, 1'b0, 32'h0000_0301, 32'hAABB_CCDD);
        @(negedge clk);
        chk("rstmid.we1", 32'(mem_write_enable), 32'(4'b1110));
        chk("rstmid.wdata1", mem_write_data, 32'hBBCC_DDAA);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid.we2", 32'(mem_write_enable), 32'(4'b0001));
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid.we_rst", 32'(mem_write_enable), 32'd0);
        chk("rstmid.rv_rst", 32'(resp_valid), 32'd0);
        chk("rstmid.addr_rst", 32'(mem_addr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rstmid.rv%0d", i), 32'(resp_valid), 32'd0);
            chk($sformatf("rstmid.ready%0d", i), 32'(req_ready), 32'd1);
        end
        run_vec('{1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0000_0000, 16'h00C0, 4'b0000,
                  32'h0000_0000, 32'hBBCC_DD00}, "rstmid.first_kept");
        run_vec('{1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0000_0000, 16'h00C1, 4'b0000,
                  32'h0000_0000, 32'h0000_0000}, "rstmid.second_dropped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
